// File: rtl/dram_cache_pkg.sv
// Shared DRAM-cache types: FSM states, tag word layout and the tag builder.
// Width macros fall back to the defaults below when the build does not set them.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef TAG_WIDTH
`define TAG_WIDTH 16
`endif
`ifndef BLANK_WIDTH
`define BLANK_WIDTH 6
`endif
`ifndef INDEX_WIDTH
`define INDEX_WIDTH 10
`endif
`ifndef OFFSET_WIDTH
`define OFFSET_WIDTH 6
`endif
`ifndef TAG_SIZE
`define TAG_SIZE (2 + `TAG_WIDTH + `BLANK_WIDTH)
`endif

package dram_cache_pkg;

  localparam int ADDR_W   = `AXI_ADDR_WIDTH;
  localparam int TAG_W    = `TAG_WIDTH;
  localparam int BLANK_W  = `BLANK_WIDTH;
  localparam int INDEX_W  = `INDEX_WIDTH;
  localparam int OFFSET_W = `OFFSET_WIDTH;
  localparam int TAG_SZ   = `TAG_SIZE;

  localparam int VALID_POS = TAG_SZ - 1;
  localparam int DIRTY_POS = TAG_SZ - 2;
  localparam int TAG_POS   = BLANK_W;
  localparam int BLANK_POS = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_RESP
  } state_t;

  function automatic logic [TAG_SZ-1:0] mk_tag(
    input logic [ADDR_W-1:0] addr,
    input logic              dirty
  );
    logic [TAG_SZ-1:0] t;
    t = '0;
    t[VALID_POS] = 1'b1;
    t[DIRTY_POS] = dirty;
    t[TAG_POS +: TAG_W] = TAG_W'(addr >> (INDEX_W + OFFSET_W));
    return t;
  endfunction

endpackage

// File: rtl/fill_arbiter_rr_arb2.sv
// Two-way round-robin grant; last_grant advances only on an accepted request.
// Port 0 wins the first tie after reset.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11): gnt = last_grant ? 2'b01 : 2'b10;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/fill_arbiter.sv
// Shares the DRAM-cache AXI write path between tag-compare fills and refills.
// Optional FILL_ARB_PERF_EN adds saturating accept/stall counters.
module fill_arbiter
  import dram_cache_pkg::*;
#(
  parameter int ADDR_WIDTH   = `AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH   = `AXI_DATA_WIDTH,
  parameter int ID_WIDTH     = `AXI_ID_WIDTH,
  parameter int TAG_SIZE     = `TAG_SIZE,
  parameter int TAG_WIDTH    = `TAG_WIDTH,
  parameter int BLANK_WIDTH  = `BLANK_WIDTH,
  parameter int INDEX_WIDTH  = `INDEX_WIDTH,
  parameter int OFFSET_WIDTH = `OFFSET_WIDTH,
  parameter int FILL_AWID    = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           fill_valid_i,
  output logic                           fill_ready_o,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fill_data_i,
  input  logic                           refill_valid_i,
  output logic                           refill_ready_o,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] refill_data_i,
  output logic [ID_WIDTH-1:0]            awid_o,
  output logic [ADDR_WIDTH-1:0]          awaddr_o,
  output logic                           awvalid_o,
  input  logic                           awready_i,
  output logic [TAG_SIZE+DATA_WIDTH-1:0] wdata_o,
  output logic                           wlast_o,
  output logic                           wvalid_o,
  input  logic                           wready_i,
  input  logic [ID_WIDTH-1:0]            bid_i,
  input  logic [1:0]                     bresp_i,
  input  logic                           bvalid_i,
  output logic                           bready_o,
  output logic                           busy_o,
  output logic                           err_o
`ifdef FILL_ARB_PERF_EN
  ,
  output logic [31:0]                    fill_cnt_o,
  output logic [31:0]                    refill_cnt_o,
  output logic [31:0]                    stall_cnt_o
`endif
);

  localparam int IO_W = INDEX_WIDTH + OFFSET_WIDTH;

  state_t                  state;
  logic [1:0]              req;
  logic [1:0]              gnt;
  logic                    accept;
  logic                    aw_done;
  logic                    w_done;
  logic                    aw_hs;
  logic                    w_hs;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    unused_bid;

  assign unused_bid = ^bid_i;
  assign awid_o     = ID_WIDTH'(FILL_AWID);
  assign wlast_o    = 1'b1;

  assign req = {refill_valid_i, fill_valid_i};

  // Ready is withheld during reset so a requester never sees a false accept.
  assign fill_ready_o   = rst_n && (state == S_IDLE) && gnt[0];
  assign refill_ready_o = rst_n && (state == S_IDLE) && gnt[1];
  assign accept         = fill_ready_o || refill_ready_o;

  assign aw_hs = awvalid_o && awready_i;
  assign w_hs  = wvalid_o && wready_i;

  always_comb begin
    sel_addr = fill_data_i[ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH];
    sel_data = fill_data_i[DATA_WIDTH-1:0];
    if (gnt[1]) begin
      sel_addr = refill_data_i[ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH];
      sel_data = refill_data_i[DATA_WIDTH-1:0];
    end
  end

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .accept (accept),
    .gnt    (gnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      awaddr_o  <= '0;
      wdata_o   <= '0;
      awvalid_o <= 1'b0;
      wvalid_o  <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      bready_o  <= 1'b0;
      busy_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            awaddr_o  <= {{TAG_WIDTH{1'b0}}, sel_addr[IO_W-1:0]};
            wdata_o   <= {mk_tag(sel_addr, gnt[0]), sel_data};
            awvalid_o <= 1'b1;
            wvalid_o  <= 1'b1;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            busy_o    <= 1'b1;
            state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (aw_hs) begin
            awvalid_o <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            wvalid_o <= 1'b0;
            w_done   <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            bready_o <= 1'b1;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (bvalid_i) begin
            if (bresp_i != 2'b00) begin
              err_o <= 1'b1;
            end
            bready_o <= 1'b0;
            busy_o   <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FILL_ARB_PERF_EN
  logic stall;

  assign stall = (state == S_ADDR) &&
                 ((awvalid_o && !awready_i) || (wvalid_o && !wready_i));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_cnt_o   <= '0;
      refill_cnt_o <= '0;
      stall_cnt_o  <= '0;
    end else begin
      if (fill_ready_o && fill_cnt_o != '1) begin
        fill_cnt_o <= fill_cnt_o + 32'd1;
      end
      if (refill_ready_o && refill_cnt_o != '1) begin
        refill_cnt_o <= refill_cnt_o + 32'd1;
      end
      if (stall && stall_cnt_o != '1) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fill_arbiter.sv
// Directed bench for fill_arbiter: grant, tag word, stalls, errors, reset.
// Counter checks run when FILL_ARB_PERF_EN is defined.
module tb_fill_arbiter;
  import dram_cache_pkg::*;

  localparam logic [31:0] FA_ADDR = 32'h0001_2340;
  localparam logic [31:0] FA_DATA = 32'h0000_00A5;
  localparam logic [31:0] RA_ADDR = 32'hABCD_0010;
  localparam logic [31:0] RA_DATA = 32'h0000_005A;
  localparam logic [23:0] TAG_A   = 24'hC0_0040;
  localparam logic [23:0] TAG_B   = 24'hAA_F340;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fill_valid_i = 1'b0;
  logic        fill_ready_o;
  logic [63:0] fill_data_i = '0;
  logic        refill_valid_i = 1'b0;
  logic        refill_ready_o;
  logic [63:0] refill_data_i = '0;
  logic [3:0]  awid_o;
  logic [31:0] awaddr_o;
  logic        awvalid_o;
  logic        awready_i = 1'b1;
  logic [55:0] wdata_o;
  logic        wlast_o;
  logic        wvalid_o;
  logic        wready_i = 1'b1;
  logic [3:0]  bid_i = '0;
  logic [1:0]  bresp_i = 2'b00;
  logic        bvalid_i = 1'b1;
  logic        bready_o;
  logic        busy_o;
  logic        err_o;
`ifdef FILL_ARB_PERF_EN
  logic [31:0] fill_cnt_o;
  logic [31:0] refill_cnt_o;
  logic [31:0] stall_cnt_o;
`endif

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fill_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fill_valid_i   (fill_valid_i),
    .fill_ready_o   (fill_ready_o),
    .fill_data_i    (fill_data_i),
    .refill_valid_i (refill_valid_i),
    .refill_ready_o (refill_ready_o),
    .refill_data_i  (refill_data_i),
    .awid_o         (awid_o),
    .awaddr_o       (awaddr_o),
    .awvalid_o      (awvalid_o),
    .awready_i      (awready_i),
    .wdata_o        (wdata_o),
    .wlast_o        (wlast_o),
    .wvalid_o       (wvalid_o),
    .wready_i       (wready_i),
    .bid_i          (bid_i),
    .bresp_i        (bresp_i),
    .bvalid_i       (bvalid_i),
    .bready_o       (bready_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
`ifdef FILL_ARB_PERF_EN
    ,
    .fill_cnt_o     (fill_cnt_o),
    .refill_cnt_o   (refill_cnt_o),
    .stall_cnt_o    (stall_cnt_o)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One write from an idle start; W is held off for wstall cycles.
  task automatic do_write(input bit port, input logic [1:0] resp,
                          input int wstall);
    if (port) refill_valid_i = 1'b1;
    else      fill_valid_i = 1'b1;
    wready_i = (wstall == 0);
    step();
    fill_valid_i = 1'b0;
    refill_valid_i = 1'b0;
    chk("dw_awvalid", awvalid_o, 1);
    repeat (wstall) step();
    wready_i = 1'b1;
    bresp_i = resp;
    step();
    chk("dw_bready", bready_o, 1);
    step();
    chk("dw_idle", busy_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_data_i = {FA_ADDR, FA_DATA};
    refill_data_i = {RA_ADDR, RA_DATA};
    step();
    step();
    chk("rst_awvalid", awvalid_o, 0);
    chk("rst_wvalid", wvalid_o, 0);
    chk("rst_bready", bready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_fready", fill_ready_o, 0);
    rst_n = 1'b1;
    step();

    // single fill, zero-wait slaves
    fill_valid_i = 1'b1;
    #1;
    chk("t1_fready", fill_ready_o, 1);
    chk("t1_rready", refill_ready_o, 0);
    step();
    chk("t1_awvalid", awvalid_o, 1);
    chk("t1_wvalid", wvalid_o, 1);
    chk("t1_awaddr", awaddr_o, 32'h0000_2340);
    chk("t1_wdata", wdata_o, {TAG_A, FA_DATA});
    chk("t1_busy", busy_o, 1);
    chk("t1_awid", awid_o, 0);
    chk("t1_wlast", wlast_o, 1);
    chk("t1_fready_busy", fill_ready_o, 0);
    step();
    chk("t1_bready", bready_o, 1);
    chk("t1_awv_drop", awvalid_o, 0);
    chk("t1_fready_resp", fill_ready_o, 0);
    step();
    chk("t1_next_ready", fill_ready_o, 1);
    chk("t1_idle", busy_o, 0);

    // both held valid: port 0 just won, so port 1 goes next
    refill_valid_i = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_fready", fill_ready_o, (i % 2 == 1));
      chk("t2_rready", refill_ready_o, (i % 2 == 0));
      step();
      chk("t2_tag", wdata_o[55:32], (i % 2 == 0) ? TAG_B : TAG_A);
      chk("t2_awaddr", awaddr_o,
          (i % 2 == 0) ? 32'h0000_0010 : 32'h0000_2340);
      step();
      step();
    end
    fill_valid_i = 1'b0;
    refill_valid_i = 1'b0;

    // AW stalled, W immediate
    awready_i = 1'b0;
    fill_valid_i = 1'b1;
    step();
    fill_valid_i = 1'b0;
    chk("t3_awvalid", awvalid_o, 1);
    chk("t3_wvalid", wvalid_o, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3_wv_drop", wvalid_o, 0);
      chk("t3_awv_hold", awvalid_o, 1);
      chk("t3_awaddr", awaddr_o, 32'h0000_2340);
      chk("t3_no_bready", bready_o, 0);
    end
    awready_i = 1'b1;
    step();
    chk("t3_bready", bready_o, 1);
    chk("t3_awv_done", awvalid_o, 0);
    step();
    chk("t3_idle", busy_o, 0);

    // sticky error on the second write
    do_write(1'b1, 2'b00, 0);
    chk("t4_err0", err_o, 0);
    do_write(1'b0, 2'b10, 0);
    chk("t4_err1", err_o, 1);
    do_write(1'b0, 2'b00, 0);
    chk("t4_err_sticky", err_o, 1);

    // reset while in S_ADDR
    awready_i = 1'b0;
    fill_valid_i = 1'b1;
    step();
    fill_valid_i = 1'b0;
    chk("t5_awvalid", awvalid_o, 1);
    rst_n = 1'b0;
    fill_valid_i = 1'b1;
    refill_valid_i = 1'b1;
    step();
    chk("t5_awv", awvalid_o, 0);
    chk("t5_wv", wvalid_o, 0);
    chk("t5_busy", busy_o, 0);
    chk("t5_err", err_o, 0);
    chk("t5_rst_ready", fill_ready_o, 0);
    rst_n = 1'b1;
    #1;
    chk("t5_tie_f", fill_ready_o, 1);
    chk("t5_tie_r", refill_ready_o, 0);
    step();
    fill_valid_i = 1'b0;
    refill_valid_i = 1'b0;
    chk("t5_tag", wdata_o[55:32], TAG_A);
    awready_i = 1'b1;
    step();
    step();
    chk("t5_idle", busy_o, 0);

`ifdef FILL_ARB_PERF_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("p_fill0", fill_cnt_o, 0);
    do_write(1'b0, 2'b00, 0);
    do_write(1'b1, 2'b00, 0);
    do_write(1'b0, 2'b00, 4);
    do_write(1'b1, 2'b00, 0);
    do_write(1'b0, 2'b00, 0);
    chk("p_fill", fill_cnt_o, 3);
    chk("p_refill", refill_cnt_o, 2);
    chk("p_stall", stall_cnt_o, 4);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
